ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the unified RAM's single data port between two requesters: the CPU pipeline MEM stage (port 0) and the in-memory-compute/loader engine (port 1). The RAM data port takes a 7-bit address and 16-bit write data, and has a registered read with 1-cycle latency.
- Sits between both requesters and the RAM data port. Default priority goes to the CPU. A starvation counter guarantees the engine forward progress. A lock mode gives the engine atomic multi-beat sequences (read operand, read operand, write result).

Parameters:
- MAX_WAIT, 4, consecutive cycles the engine may be denied before it gets forced priority (1..15).
- LOCK_MAX, 8, maximum granted beats in one locked sequence (1..15).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous reset, active high.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  7  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata holds the result of the CPU read granted the previous cycle.
- cpu_rdata  out  16  equal to ram_rdata.
- imc_req  in  1  engine access request.
- imc_lock  in  1  hold the port after this beat.
- imc_we  in  1  engine write / read.
- imc_addr  in  7  engine word address.
- imc_wdata  in  16  engine write data.
- imc_gnt  out  1  engine access accepted this cycle (combinational).
- imc_rvalid  out  1  engine read data valid.
- imc_rdata  out  16  equal to ram_rdata.
- ram_we  out  1  RAM write enable.
- ram_addr  out  7  RAM data address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM registered read data.

Behaviour:
- States: ARB, LOCKED.
- Reset values: state=ARB, wait_cnt=0, lock_cnt=0, cpu_rvalid=imc_rvalid=0. While rst=1: cpu_gnt=imc_gnt=0 and ram_we=0.
- Grant rules, evaluated combinationally each cycle; at most one grant per cycle:
  - ARB: if imc_req and wait_cnt==MAX_WAIT, grant imc. Else if cpu_req, grant cpu. Else if imc_req, grant imc.
  - LOCKED: grant imc if imc_req; cpu_gnt=0 always.
- RAM drive:
  - ram_addr/ram_wdata come from the granted requester.
  - With no grant, ram_addr=cpu_addr and ram_wdata=cpu_wdata.
  - ram_we = granted requester's we; 0 when nothing is granted.
  - A write commits at the posedge ending its grant cycle.
- Read latency: x_rvalid <= x_gnt & ~x_we, registered, so it is high exactly 1 cycle after the read grant. Writes never raise rvalid.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle imc_req=1 and imc_gnt=0.
  - Clears on imc_gnt or when imc_req=0.
  - Does not increment in LOCKED.
- Lock:
  - ARB to LOCKED on an imc grant with imc_lock=1; lock_cnt<=1.
  - In LOCKED, each imc grant increments lock_cnt.
  - LOCKED to ARB on any of:
    - an imc grant with imc_lock=0 (that beat completes);
    - imc_req=0 for one cycle;
    - lock_cnt==LOCK_MAX after a granted beat, which is a forced exit even if imc_lock=1.
  - A locked beat granted in the exit cycle still completes normally.
- Simultaneous events:
  - cpu_req and imc_req together with wait_cnt<MAX_WAIT: cpu wins, wait_cnt increments.
  - At MAX_WAIT: imc wins once, wait_cnt clears, and cpu sees gnt=0 that cycle.
- Reset mid-operation: pending rvalids cleared, LOCKED aborted to ARB, no RAM write during reset cycles.
- Requester contract: a requester holds req/we/addr/wdata stable until it sees gnt. The arbiter never drops a granted beat.

Test Plan:
- CPU-only read of addr 29 (RAM holds 22): cpu_gnt same cycle, cpu_rvalid=1 and cpu_rdata=22 next cycle, imc_rvalid=0.
- Both request continuously with MAX_WAIT=4: cpu granted 4 cycles, then imc granted on the 5th. Pattern repeats every 5 cycles; ram_we never set without a grant.
- Engine locked sequence: read 29, read 30 (lock=1), then write 31=55 (lock=0), with cpu_req held high. cpu_gnt=0 for all 3 beats, then cpu granted next cycle; a later read of 31 returns 55.
- Lock overrun, LOCK_MAX=8: imc holds lock=1 for 10 beats. Exit after the 8th granted beat; a cpu grant follows when cpu_req=1.
- Reset asserted during LOCKED with a read just granted: no rvalid next cycle, state ARB, ram_we=0 throughout reset, cpu granted first cycle after rst drops.
- CPU write addr 5=0xABCD followed back-to-back by a CPU read of 5: rvalid after the read only, data 0xABCD.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single RAM data port between the CPU MEM stage (port 0) and the
// in-memory-compute/loader engine (port 1). The CPU has default priority.
// A wait counter forces an engine grant after MAX_WAIT denied cycles.
// A lock mode keeps the port for up to LOCK_MAX engine beats.
// The RAM has a 1-cycle registered read.
module ram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [6:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        imc_req,
  input  logic        imc_lock,
  input  logic        imc_we,
  input  logic [6:0]  imc_addr,
  input  logic [15:0] imc_wdata,
  output logic        imc_gnt,
  output logic        imc_rvalid,
  output logic [15:0] imc_rdata,
  output logic        ram_we,
  output logic [6:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  wait_cnt_r, wait_cnt_s;
  logic [3:0]  lock_cnt_r, lock_cnt_s;
  logic [3:0]  lock_inc_s;
  logic        cpu_gnt_s, imc_gnt_s;
  logic        cpu_rvalid_r, imc_rvalid_r;

  // Grant decision: a forced engine grant beats the CPU; no grants during reset.
  always_comb begin
    cpu_gnt_s = 1'b0;
    imc_gnt_s = 1'b0;
    if (rst) begin
      cpu_gnt_s = 1'b0;
      imc_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ST_ARB: begin
          if (imc_req && (wait_cnt_r == MAX_WAIT_C)) begin
            imc_gnt_s = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else if (imc_req) begin
            imc_gnt_s = 1'b1;
          end else begin
            imc_gnt_s = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (imc_req) begin
            imc_gnt_s = 1'b1;
          end else begin
            imc_gnt_s = 1'b0;
          end
        end
        default: begin
          cpu_gnt_s = 1'b0;
          imc_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: the granted requester drives the port; the CPU drives it when idle.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (imc_gnt_s) begin
      ram_addr  = imc_addr;
      ram_wdata = imc_wdata;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
    ram_we = (cpu_gnt_s & cpu_we) | (imc_gnt_s & imc_we);
  end

  // Next-state logic for the lock FSM, the starvation counter and the beat counter.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    lock_cnt_s = lock_cnt_r;
    lock_inc_s = lock_cnt_r + 4'd1;

    if (!imc_req || imc_gnt_s) begin
      wait_cnt_s = 4'd0;
    end else if ((state_r == ST_ARB) && (wait_cnt_r < MAX_WAIT_C)) begin
      wait_cnt_s = wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_s = wait_cnt_r;
    end

    case (state_r)
      ST_ARB: begin
        // With LOCK_MAX of 1 the first beat already reaches the limit, so stay in ARB.
        if (imc_gnt_s && imc_lock && (LOCK_MAX_C > 4'd1)) begin
          state_s    = ST_LOCKED;
          lock_cnt_s = 4'd1;
        end else begin
          state_s    = ST_ARB;
          lock_cnt_s = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (!imc_req) begin
          state_s    = ST_ARB;
          lock_cnt_s = 4'd0;
        end else if (!imc_lock || (lock_inc_s >= LOCK_MAX_C)) begin
          state_s    = ST_ARB;
          lock_cnt_s = lock_inc_s;
        end else begin
          state_s    = ST_LOCKED;
          lock_cnt_s = lock_inc_s;
        end
      end
      default: begin
        state_s    = ST_ARB;
        lock_cnt_s = 4'd0;
      end
    endcase
  end

  // State and read-valid registers; rvalid marks the cycle after a granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_ARB;
      wait_cnt_r   <= 4'd0;
      lock_cnt_r   <= 4'd0;
      cpu_rvalid_r <= 1'b0;
      imc_rvalid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      lock_cnt_r   <= lock_cnt_s;
      cpu_rvalid_r <= cpu_gnt_s & ~cpu_we;
      imc_rvalid_r <= imc_gnt_s & ~imc_we;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign imc_gnt    = imc_gnt_s;
  assign cpu_rvalid = cpu_rvalid_r;
  assign imc_rvalid = imc_rvalid_r;
  assign cpu_rdata  = ram_rdata;
  assign imc_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Table-driven bench with a behavioural RAM and a read-data scoreboard.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        imc_req, imc_lock, imc_we, imc_gnt, imc_rvalid;
  logic [6:0]  imc_addr;
  logic [15:0] imc_wdata, imc_rdata;
  logic        ram_we;
  logic [6:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  ram_port_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .imc_req(imc_req), .imc_lock(imc_lock), .imc_we(imc_we), .imc_addr(imc_addr),
    .imc_wdata(imc_wdata), .imc_gnt(imc_gnt), .imc_rvalid(imc_rvalid), .imc_rdata(imc_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with 1-cycle registered read (read-before-write).
  logic [15:0] ram [0:127];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [6:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        imc_req, imc_lock, imc_we;
    logic [6:0]  imc_addr;
    logic [15:0] imc_wdata;
    logic        exp_cg, exp_ig;
  } vec_t;

  typedef struct {
    logic        cv;
    logic        iv;
    logic [15:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [15:0] ref_mem [0:127];
  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  int          hand_at = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, cur, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic cq, input logic cw, input logic [6:0] ca,
                     input logic [15:0] cd, input logic iq, input logic il, input logic iw,
                     input logic [6:0] ia, input logic [15:0] id, input logic ecg,
                     input logic eig);
    vec_t v;
    v.rst = r; v.cpu_req = cq; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.imc_req = iq; v.imc_lock = il; v.imc_we = iw; v.imc_addr = ia; v.imc_wdata = id;
    v.exp_cg = ecg; v.exp_ig = eig;
    vecs.push_back(v);
  endtask

  task automatic add_idle();
    add(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
    imc_req = v.imc_req; imc_lock = v.imc_lock; imc_we = v.imc_we;
    imc_addr = v.imc_addr; imc_wdata = v.imc_wdata;
    #1;
  endtask

  // Compare the combinational outputs against the expected grants.
  task automatic check_comb(input vec_t v, input logic ecg, input logic eig);
    logic        e_we;
    logic [6:0]  e_addr;
    logic [15:0] e_wd;
    e_we   = (ecg & v.cpu_we) | (eig & v.imc_we);
    e_addr = eig ? v.imc_addr : v.cpu_addr;
    e_wd   = eig ? v.imc_wdata : v.cpu_wdata;
    chk("cpu_gnt", {15'd0, cpu_gnt}, {15'd0, ecg});
    chk("imc_gnt", {15'd0, imc_gnt}, {15'd0, eig});
    chk("ram_we", {15'd0, ram_we}, {15'd0, e_we});
    chk("ram_addr", {9'd0, ram_addr}, {9'd0, e_addr});
    chk("ram_wdata", ram_wdata, e_wd);
  endtask

  // Record what should appear on the read side next cycle and update the reference memory.
  task automatic push_expect(input vec_t v, input logic ecg, input logic eig);
    sb_t e;
    e.cv   = ecg & ~v.cpu_we;
    e.iv   = eig & ~v.imc_we;
    e.data = ref_mem[eig ? v.imc_addr : v.cpu_addr];
    sb.push_back(e);
    if (ecg && v.cpu_we) ref_mem[v.cpu_addr] = v.cpu_wdata;
    if (eig && v.imc_we) ref_mem[v.imc_addr] = v.imc_wdata;
  endtask

  task automatic clock_and_pop();
    sb_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cpu_rvalid", {15'd0, cpu_rvalid}, {15'd0, e.cv});
    chk("imc_rvalid", {15'd0, imc_rvalid}, {15'd0, e.iv});
    if (e.cv) chk("cpu_rdata", cpu_rdata, e.data);
    if (e.iv) chk("imc_rdata", imc_rdata, e.data);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    check_comb(v, v.exp_cg, v.exp_ig);
    push_expect(v, v.exp_cg, v.exp_ig);
    clock_and_pop();
  endtask

  // Reset arrives mid-cycle just after a locked engine read was granted.
  task automatic reset_mid_lock();
    vec_t v;
    v.rst = 1'b0; v.cpu_req = 1'b1; v.cpu_we = 1'b0; v.cpu_addr = 7'd40; v.cpu_wdata = 16'd0;
    v.imc_req = 1'b1; v.imc_lock = 1'b1; v.imc_we = 1'b0; v.imc_addr = 7'd29;
    v.imc_wdata = 16'd0; v.exp_cg = 1'b0; v.exp_ig = 1'b1;
    drive(v);
    check_comb(v, 1'b0, 1'b1);
    rst = 1'b1;
    v.rst = 1'b1;
    #1;
    check_comb(v, 1'b0, 1'b0);
    push_expect(v, 1'b0, 1'b0);
    clock_and_pop();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i]     = 16'(i * 3);
      ref_mem[i] = 16'(i * 3);
    end
    ram[29] = 16'd22; ref_mem[29] = 16'd22;
    ram[30] = 16'd7;  ref_mem[30] = 16'd7;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 7'd0; cpu_wdata = 16'd0;
    imc_req = 1'b0; imc_lock = 1'b0; imc_we = 1'b0; imc_addr = 7'd0; imc_wdata = 16'd0;

    // Reset: requests are ignored and no write reaches the RAM.
    add(1'b1, 1'b1, 1'b1, 7'd5, 16'h1111, 1'b1, 1'b0, 1'b1, 7'd6, 16'h2222, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 7'd5, 16'h1111, 1'b1, 1'b0, 1'b1, 7'd6, 16'h2222, 1'b0, 1'b0);
    add_idle();
    // CPU read of 29.
    add(1'b0, 1'b1, 1'b0, 7'd29, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add_idle();
    // CPU write 5 then back-to-back read of 5.
    add(1'b0, 1'b1, 1'b1, 7'd5, 16'hABCD, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd5, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add_idle();
    // Continuous contention: four CPU grants then one engine grant.
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b1, 1'b0, 7'd10, 16'd0, 1'b1, 1'b0, 1'b0, 7'd11, 16'd0,
          (i % 5) != 4, (i % 5) == 4);
    add_idle();
    // Engine-only read.
    add(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0, 1'b0, 7'd29, 16'd0, 1'b0, 1'b1);
    add_idle();
    // Locked sequence against a CPU that keeps requesting.
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b1, 1'b1, 1'b0, 7'd29, 16'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b1, 1'b1, 1'b0, 7'd29, 16'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b1, 1'b1, 1'b0, 7'd30, 16'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b1, 1'b0, 1'b1, 7'd31, 16'd55, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd31, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add_idle();
    // Lock released by dropping imc_req: CPU is still blocked that cycle.
    add(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b1, 1'b0, 7'd50, 16'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add_idle();
    // Lock overrun: forced exit after eight beats.
    add(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b1, 1'b0, 7'd60, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++)
      add(1'b0, 1'b1, 1'b0, 7'd41, 16'd0, 1'b1, 1'b1, 1'b0, 7'd60, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, 1'b0, 7'd41, 16'd0, 1'b1, 1'b1, 1'b0, 7'd60, 16'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd41, 16'd0, 1'b1, 1'b1, 1'b0, 7'd60, 16'd0, 1'b0, 1'b1);
    add_idle();
    add_idle();
    // Enter LOCKED before the mid-cycle reset.
    add(1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b1, 1'b0, 7'd50, 16'd0, 1'b0, 1'b1);
    hand_at = vecs.size();
    add(1'b1, 1'b1, 1'b1, 7'd5, 16'h1111, 1'b1, 1'b1, 1'b1, 7'd6, 16'h2222, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd40, 16'd0, 1'b1, 1'b1, 1'b0, 7'd29, 16'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 7'd5, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0);
    add_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == hand_at) reset_mid_lock();
      cur = i;
      run_vec(vecs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
